// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding word fetch at a time, registered
// valid/ready hand-off to the datapath, retire counter and misaligned-target trap.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pcsrc,
  input  logic [31:0] pctarget,
  output logic        fetch_fault,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    TRAP  = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        armed_r;
  logic [31:0] fetch_pc_r;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] instret_r;
  logic [31:0] next_pc_s;
  logic        req_r;
  logic        valid_r;
  logic        fault_r;
  logic        capture_s;
  logic        consume_s;
  logic        misaligned_s;

  assign imem_req    = req_r;
  assign imem_addr   = fetch_pc_r;
  assign instr       = instr_r;
  assign pc          = pc_r;
  assign pcplus4     = pc_r + 32'd4;
  assign instr_valid = valid_r;
  assign fetch_fault = fault_r;
  assign instret     = instret_r;

  // Next-state decode plus capture/consume strobes for the datapath registers
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    consume_s    = 1'b0;
    next_pc_s    = pcsrc ? pctarget : pcplus4;
    misaligned_s = (next_pc_s[1:0] != 2'b00);
    case (state_r)
      IDLE: begin
        if (armed_r) state_next_s = REQ;
        else         state_next_s = IDLE;
      end
      REQ: begin
        if (imem_gnt) state_next_s = WAIT;
        else          state_next_s = REQ;
      end
      WAIT: begin
        if (imem_rvalid) begin
          capture_s    = 1'b1;
          state_next_s = VALID;
        end else begin
          state_next_s = WAIT;
        end
      end
      VALID: begin
        if (instr_ready) begin
          consume_s = 1'b1;
          if (misaligned_s) state_next_s = TRAP;
          else              state_next_s = REQ;
        end else begin
          state_next_s = VALID;
        end
      end
      TRAP:    state_next_s = TRAP;
      default: state_next_s = IDLE;
    endcase
  end

  // State register; armed_r keeps IDLE through the first edge after reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      armed_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      armed_r <= 1'b1;
    end
  end

  // Handshake and trap outputs registered from the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_r   <= 1'b0;
      valid_r <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      req_r   <= (state_next_s == REQ);
      valid_r <= (state_next_s == VALID);
      fault_r <= (state_next_s == TRAP);
    end
  end

  // Fetch address, presented instruction/pc and retired-instruction count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_r <= RESET_PC;
      pc_r       <= RESET_PC;
      instr_r    <= 32'h0000_0013;
      instret_r  <= 32'd0;
    end else begin
      if (capture_s) begin
        instr_r <= imem_rdata;
        pc_r    <= fetch_pc_r;
      end
      if (consume_s) begin
        instret_r <= instret_r + 32'd1;
        if (!misaligned_s) fetch_pc_r <= next_pc_s;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a transaction-level model of the program
// counter and retire count, a latency-randomized memory and a randomized consumer.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_gnt, imem_rvalid, instr_ready, pcsrc;
  logic [31:0] imem_rdata, pctarget;
  logic        imem_req, instr_valid, fetch_fault;
  logic [31:0] imem_addr, instr, pc, pcplus4, instret;
  logic        w_req, w_valid, w_fault;
  logic [31:0] w_addr, w_instr, w_pc, w_pcplus4, w_instret;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .pc(pc), .pcplus4(pcplus4), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pcsrc(pcsrc), .pctarget(pctarget),
    .fetch_fault(fetch_fault), .instret(instret)
  );

  // Second instance starting just below the top of the address space
  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(w_instr), .pc(w_pc), .pcplus4(w_pcplus4), .instr_valid(w_valid),
    .instr_ready(instr_ready), .pcsrc(pcsrc), .pctarget(pctarget),
    .fetch_fault(w_fault), .instret(w_instret)
  );

  int          n_tests, n_fail;
  logic [31:0] model_pc, model_instret;
  bit          trapped;
  bit          pending, gnt_given, stray_en, br_en;
  int          rsp_wait, gnt_hold, max_g, max_rv, ready_pct, pcsrc_pct, br_hold;
  int          idle_cnt, n_consumed;
  logic [31:0] rsp_addr, br_at, br_tgt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000)      return 32'h00E0_0093;
    else if (a == 32'h0000_0004) return 32'h3E80_0113;
    else                         return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  // One cycle: check outputs against the model, then drive consumer and memory.
  task automatic step();
    logic [31:0] nxt;
    @(negedge clk);
    if (trapped) begin
      n_tests++;
      if ({fetch_fault, imem_req, instr_valid} !== 3'b100) begin
        n_fail++; $display("FAIL trap_state: fault/req/valid=%b want 100", {fetch_fault, imem_req, instr_valid});
      end
      idle_cnt = 0;
    end else begin
      n_tests++;
      if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL fault_spurious: got %b want 0", fetch_fault); end
    end
    n_tests++;
    if (instret !== model_instret) begin n_fail++; $display("FAIL instret: got %0d want %0d", instret, model_instret); end
    if (instr_valid === 1'b1) begin
      n_tests++;
      if (instr !== mem_word(model_pc) || pc !== model_pc || pcplus4 !== model_pc + 32'd4 || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL presented: instr=%h pc=%h pc4=%h req=%b want instr=%h pc=%h pc4=%h req=0",
                 instr, pc, pcplus4, imem_req, mem_word(model_pc), model_pc, model_pc + 32'd4);
      end
    end
    if (imem_req === 1'b1) begin
      n_tests++;
      if (imem_addr !== model_pc) begin n_fail++; $display("FAIL req_addr: got %h want %h", imem_addr, model_pc); end
    end
    idle_cnt++;
    if (idle_cnt > 60) begin
      n_tests++; n_fail++; $display("FAIL watchdog: no consume within 60 cycles, got none want one");
      idle_cnt = 0;
    end
    // consumer
    instr_ready = ($urandom_range(99, 0) < ready_pct);
    pcsrc       = ($urandom_range(99, 0) < pcsrc_pct);
    pctarget    = $urandom() & 32'hFFFF_FFFC;
    if (instr_valid === 1'b1 && !trapped) begin
      if (br_en && model_pc == br_at) begin
        instr_ready = 1'b1; pcsrc = 1'b1; pctarget = br_tgt; gnt_hold = br_hold;
      end
      if (instr_ready) begin
        model_instret = model_instret + 32'd1;
        nxt = pcsrc ? pctarget : model_pc + 32'd4;
        if (nxt[1:0] != 2'b00) trapped = 1'b1;
        else                   model_pc = nxt;
        n_consumed++;
      end
      idle_cnt = 0;
    end
    // memory: grant after gnt_hold cycles, respond rsp_wait cycles after the grant edge
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = $urandom();
    if (gnt_given) begin gnt_given = 1'b0; pending = 1'b1; rsp_wait = $urandom_range(max_rv, 0); end
    if (pending) begin
      if (rsp_wait == 0) begin imem_rvalid = 1'b1; imem_rdata = mem_word(rsp_addr); pending = 1'b0; end
      else rsp_wait--;
    end else if (imem_req === 1'b1) begin
      if (gnt_hold == 0) begin
        imem_gnt = 1'b1; gnt_given = 1'b1; rsp_addr = imem_addr; gnt_hold = $urandom_range(max_g, 0);
      end else gnt_hold--;
    end
    if (stray_en && !pending && !gnt_given && !imem_rvalid && $urandom_range(3, 0) == 0) imem_rvalid = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if ({imem_req, imem_addr, instr, pc, pcplus4, instr_valid, fetch_fault, instret} !==
        {1'b0, 32'h0, 32'h0000_0013, 32'h0, 32'h4, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_values: req=%b addr=%h instr=%h pc=%h pc4=%h valid=%b fault=%b instret=%h want 0/0/00000013/0/4/0/0/0",
               imem_req, imem_addr, instr, pc, pcplus4, instr_valid, fetch_fault, instret);
    end
    n_tests++;
    if ({w_addr, w_pc, w_pcplus4} !== {32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0}) begin
      n_fail++; $display("FAIL reset_wrap: addr=%h pc=%h pc4=%h want fffffffc/fffffffc/0", w_addr, w_pc, w_pcplus4);
    end
    pending = 1'b0; gnt_given = 1'b0; gnt_hold = 0; trapped = 1'b0;
    model_pc = 32'h0; model_instret = 32'h0; idle_cnt = 0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0; pcsrc = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_knobs(input int g, input int rv, input int rdy, input int src, input bit stray);
    max_g = g; max_rv = rv; ready_pct = rdy; pcsrc_pct = src; stray_en = stray; br_en = 1'b0;
  endtask

  task automatic test_reset();
    set_knobs(0, 0, 100, 0, 1'b0);
    do_reset();
    step();
    n_tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_release: req=%b valid=%b want 0 0", imem_req, instr_valid);
    end
  endtask

  task automatic test_free_run();
    logic [7:0] exp_req, exp_val;
    exp_req = 8'b1001_0010;  // bit k = value observed after edge Ek
    exp_val = 8'b0100_1000;
    set_knobs(0, 0, 100, 0, 1'b0);
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      n_tests++;
      if (imem_req !== exp_req[k] || instr_valid !== exp_val[k]) begin
        n_fail++; $display("FAIL free_run_timing E%0d: req=%b valid=%b want %b %b", k, imem_req, instr_valid, exp_req[k], exp_val[k]);
      end
      if (k == 1 || k == 4) begin
        n_tests++;
        if (imem_addr !== ((k == 1) ? 32'h0 : 32'h4)) begin
          n_fail++; $display("FAIL free_run_addr E%0d: got %h", k, imem_addr);
        end
      end
      if (k == 3) begin
        n_tests++;
        if (instr !== 32'h00E0_0093 || pc !== 32'h0 || pcplus4 !== 32'h4) begin
          n_fail++; $display("FAIL free_run_first: instr=%h pc=%h pc4=%h want 00e00093 0 4", instr, pc, pcplus4);
        end
      end
      if (k == 6) begin
        n_tests++;
        if (instr !== 32'h3E80_0113 || pc !== 32'h4) begin
          n_fail++; $display("FAIL free_run_second: instr=%h pc=%h want 3e800113 4", instr, pc);
        end
      end
      if (k == 7) begin
        n_tests++;
        if (instret !== 32'd2) begin n_fail++; $display("FAIL free_run_instret: got %0d want 2", instret); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] i0, p0;
    set_knobs(1, 1, 0, 0, 1'b1);
    do_reset();
    for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) step();
    n_tests++;
    if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %b want 1", instr_valid); end
    i0 = instr; p0 = pc;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (instr !== i0 || pc !== p0 || instr_valid !== 1'b1 || imem_req !== 1'b0 || instret !== 32'd0) begin
        n_fail++; $display("FAIL bp_hold: instr=%h pc=%h valid=%b req=%b instret=%0d want %h %h 1 0 0",
                           instr, pc, instr_valid, imem_req, instret, i0, p0);
      end
    end
    ready_pct = 100;
    repeat (8) step();
  endtask

  task automatic test_branch();
    int cnt;
    set_knobs(0, 0, 100, 0, 1'b0);
    br_en = 1'b1; br_at = 32'h8; br_tgt = 32'h40; br_hold = 3;
    do_reset();
    for (int i = 0; i < 40 && !(imem_req === 1'b1 && imem_addr === 32'h40); i++) step();
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      n_fail++; $display("FAIL branch_req: req=%b addr=%h want 1 00000040", imem_req, imem_addr);
    end
    cnt = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (imem_req !== 1'b1) break;
      cnt++;
      n_tests++;
      if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL branch_addr_hold: got %h want 00000040", imem_addr); end
    end
    n_tests++;
    if (cnt != 4) begin n_fail++; $display("FAIL branch_req_cycles: got %0d want 4", cnt); end
    br_en = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_misaligned();
    set_knobs(0, 0, 100, 0, 1'b0);
    br_en = 1'b1; br_at = 32'h4; br_tgt = 32'h42; br_hold = 0;
    do_reset();
    for (int i = 0; i < 30 && !trapped; i++) step();
    step();
    n_tests++;
    if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL trap_flag: got %b want 1", fetch_fault); end
    for (int i = 0; i < 10; i++) begin
      step();
      n_tests++;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL trap_req: got %b want 0", imem_req); end
    end
    br_en = 1'b0;
    do_reset();
    step();
    n_tests++;
    if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL trap_cleared: got %b want 0", fetch_fault); end
    for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) step();
    n_tests++;
    if (instr_valid !== 1'b1 || pc !== 32'h0) begin
      n_fail++; $display("FAIL trap_restart: valid=%b pc=%h want 1 00000000", instr_valid, pc);
    end
  endtask

  task automatic test_wrap();
    set_knobs(0, 0, 100, 0, 1'b0);
    do_reset();
    for (int i = 0; i < 20 && w_valid !== 1'b1; i++) step();
    n_tests++;
    if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_pcplus4 !== 32'h0) begin
      n_fail++; $display("FAIL wrap_first: valid=%b pc=%h pc4=%h want 1 fffffffc 0", w_valid, w_pc, w_pcplus4);
    end
    for (int i = 0; i < 20 && w_req !== 1'b1; i++) step();
    n_tests++;
    if (w_req !== 1'b1 || w_addr !== 32'h0 || w_fault !== 1'b0) begin
      n_fail++; $display("FAIL wrap_next: req=%b addr=%h fault=%b want 1 0 0", w_req, w_addr, w_fault);
    end
    repeat (6) step();
    n_tests++;
    if (w_fault !== 1'b0) begin n_fail++; $display("FAIL wrap_fault: got %b want 0", w_fault); end
  endtask

  task automatic test_reset_mid_wait();
    set_knobs(0, 50, 100, 0, 1'b0);
    do_reset();
    for (int i = 0; i < 20 && !pending; i++) step();
    step();
    do_reset();
    max_rv = 0;
    pending = 1'b1; rsp_wait = 0; rsp_addr = 32'h0000_0100;
    for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) step();
    n_tests++;
    if (instr_valid !== 1'b1 || instr !== 32'h00E0_0093 || pc !== 32'h0) begin
      n_fail++; $display("FAIL mid_wait_restart: valid=%b instr=%h pc=%h want 1 00e00093 0", instr_valid, instr, pc);
    end
    repeat (6) step();
  endtask

  task automatic test_random();
    set_knobs(3, 3, 60, 30, 1'b1);
    do_reset();
    n_consumed = 0;
    repeat (800) step();
    n_tests++;
    if (n_consumed < 40) begin n_fail++; $display("FAIL random_progress: got %0d consumes want >= 40", n_consumed); end
  endtask

  initial begin
    reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; pcsrc = 1'b0; pctarget = 32'h0;
    n_tests = 0; n_fail = 0; n_consumed = 0;
    test_reset();
    test_free_run();
    test_backpressure();
    test_branch();
    test_misaligned();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
